// File: rtl/icache_dm_ro_if.sv
// Processor fetch port and line-refill port of the direct-mapped instruction cache.
// slave = the cache; master = the IF stage plus instruction memory around it.
interface icache_dm_ro_if #(
  parameter int ADDR_W = 30
);
  logic              proc_read;
  logic              proc_write;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_wdata;
  logic [31:0]       proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_addr;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata;
  logic              mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_dm_ro.sv
// Direct-mapped read-only instruction cache: 4-word lines, hit returns in the same cycle,
// a miss stalls the fetch until the line is refilled from instruction memory.
module icache_dm_ro #(
  parameter int ADDR_W = 30,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = ADDR_W - 2 - IDX_W
) (
  input  logic           clk,
  input  logic           rst,
  icache_dm_ro_if.slave  bus
);
  localparam int NUM_LINES = 2 ** IDX_W;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t            state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [3:0][31:0]  data_q [NUM_LINES];
  logic [ADDR_W-3:0] miss_addr;
  logic              mem_read_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_off;
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic              hit;
  logic              fill_done;
  logic              unused_inputs;

  assign req_tag  = bus.proc_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = bus.proc_addr[2 +: IDX_W];
  assign req_off  = bus.proc_addr[1:0];
  assign miss_tag = miss_addr[ADDR_W-3 -: TAG_W];
  assign miss_idx = miss_addr[IDX_W-1:0];

  // proc_write is deliberately not part of the request: read+write behaves as a read.
  assign hit       = bus.proc_read && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_done = (state_q == FILL) && bus.mem_ready;

  always_comb begin
    bus.proc_rdata = '0;
    bus.proc_stall = 1'b1;
    if (state_q == IDLE) begin
      bus.proc_stall = bus.proc_read && !hit;
      if (hit) bus.proc_rdata = data_q[req_idx][req_off];
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_addr  = mem_read_q ? miss_addr : '0;
  assign bus.mem_write = 1'b0;
  assign bus.mem_wdata = '0;

  assign unused_inputs = bus.proc_write ^ (^bus.proc_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_addr  <= '0;
      mem_read_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.proc_read && !hit) begin
            miss_addr  <= bus.proc_addr[ADDR_W-1:2];
            mem_read_q <= 1'b1;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            valid_q[miss_idx] <= 1'b1;
            mem_read_q        <= 1'b0;
            state_q           <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays are not reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && fill_done) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_icache_dm_ro.sv
// Directed bench for icache_dm_ro: stimulus pushes expected fetch words, a negedge monitor
// pops and compares whenever the cache returns a word with stall low.
module tb_icache_dm_ro;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  icache_dm_ro_if #(.ADDR_W(30)) bus ();

  icache_dm_ro #(.ADDR_W(30), .IDX_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory image: word at word-address a
  function automatic logic [31:0] word_val(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h0000_0010;
  endfunction

  function automatic logic [127:0] line_val(input logic [27:0] la);
    logic [127:0] l;
    logic [1:0]   k2;
    for (int k = 0; k < 4; k++) begin
      k2 = k[1:0];
      l[32*k +: 32] = word_val({la, k2});
    end
    return l;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.proc_read && !bus.proc_stall) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got %0h want none", bus.proc_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check($sformatf("rdata@%0h", bus.proc_addr), {96'b0, bus.proc_rdata}, {96'b0, mon_exp});
      end
    end
  end

  // Issue one fetch, serve the refill 3 cycles after mem_read rises, return when stall drops.
  task automatic fetch(input logic [29:0] a, input bit miss, input bit wr = 1'b0);
    int stalls = 0;
    int cyc    = 0;
    int mr     = 0;
    bit done   = 1'b0;
    bit saw    = 1'b0;
    bit just   = 1'b0;
    @(posedge clk); #1;
    bus.proc_read  = 1'b1;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    exp_q.push_back(word_val(a));
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.mem_ready = 1'b0;
      if (just) begin
        check($sformatf("mem_read_drop@%0h", a), {127'b0, bus.mem_read}, 128'd0);
        just = 1'b0;
      end
      if (!bus.proc_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (bus.mem_read) begin
          if (!saw) check($sformatf("mem_addr@%0h", a), {100'b0, bus.mem_addr}, {100'b0, a[29:2]});
          saw = 1'b1;
          mr++;
          if (mr == 3) begin
            bus.mem_rdata = line_val(a[29:2]);
            bus.mem_ready = 1'b1;
            just = 1'b1;
          end
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout@%0h: got stall=1 want stall=0 within 40 cycles", a);
    end
    check($sformatf("stall_cycles@%0h", a), stalls, miss ? 4 : 0);
    check($sformatf("mem_read_seen@%0h", a), {127'b0, saw}, {127'b0, miss});
    check($sformatf("mem_write@%0h", a), {bus.mem_write, bus.mem_wdata[126:0]}, 128'd0);
    bus.proc_write = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst            = 1'b1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = 32'hDEAD_BEEF;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall",    {127'b0, bus.proc_stall}, 128'd0);
    check("rst_mem_read", {127'b0, bus.mem_read},   128'd0);
    check("rst_mem_addr", {100'b0, bus.mem_addr},   128'd0);
    check("rst_rdata",    {96'b0, bus.proc_rdata},  128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // cold miss, then same-line hits (one with proc_write also high)
    fetch(30'h0, 1'b1);
    fetch(30'h1, 1'b0);
    fetch(30'h2, 1'b0, 1'b1);
    fetch(30'h3, 1'b0);

    // conflicts on index 0, including the top tag bit
    fetch(30'h20, 1'b1);
    fetch(30'h0, 1'b1);
    fetch(30'h2000_0000, 1'b1);
    fetch(30'h0, 1'b1);

    // reset in the middle of a fill
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h40;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_read && n < 10);
    check("mid_fill_mem_read", {127'b0, bus.mem_read}, 128'd1);
    @(negedge clk);
    rst           = 1'b1;
    bus.proc_read = 1'b0;
    @(negedge clk);
    check("post_rst_mem_read", {127'b0, bus.mem_read},   128'd0);
    check("post_rst_stall",    {127'b0, bus.proc_stall}, 128'd0);
    check("post_rst_rdata",    {96'b0, bus.proc_rdata},  128'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_rdata = ~line_val(28'h10);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("late_ready_mem_read", {127'b0, bus.mem_read}, 128'd0);
    fetch(30'h0, 1'b1);
    fetch(30'h40, 1'b1);

    // write-only request is ignored and does not disturb line 1
    fetch(30'h4, 1'b1);
    @(posedge clk); #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b1;
    bus.proc_addr  = 30'h24;
    @(negedge clk);
    check("wr_stall",     {127'b0, bus.proc_stall}, 128'd0);
    check("wr_mem_read",  {127'b0, bus.mem_read},   128'd0);
    check("wr_mem_write", {127'b0, bus.mem_write},  128'd0);
    check("wr_rdata",     {96'b0, bus.proc_rdata},  128'd0);
    @(negedge clk);
    check("wr_mem_read_next", {127'b0, bus.mem_read}, 128'd0);
    bus.proc_write = 1'b0;
    fetch(30'h4, 1'b0);

    // index sweep: idx0 holds tag 2, idx1 holds addr 4
    for (int i = 0; i < 8; i++) fetch(30'(i * 4), i != 1);
    for (int i = 0; i < 8; i++) fetch(30'(i * 4 + (i % 4)), 1'b0);

    idle();
    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
